// File: rtl/instr_cycle_sequencer.sv
// Fetch/decode/execute sequencer: fetches one instruction word per pass, gates execution through the CEX window,
// and halts on a halt instruction or a memory timeout. Optional breakpoint logic is enabled by SEQ_BREAKPOINT_EN.
module instr_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             mar_load,
  output logic             mem_req,
  output logic             mem_rw,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             exec_start,
  input  logic             exec_done,
  input  logic             halt_instr,
  input  logic             cex_load,
  input  logic             cex_cond,
  input  logic [2:0]       cex_tc,
  input  logic [2:0]       cex_fc,
  output logic             skipped,
  output logic             cex_active,
  output logic             halted,
  output logic             bus_err,
  output logic [RET_W-1:0] ret_count,
  output logic [2:0]       state_o
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic [15:0]      bkpt_addr,
  input  logic             bkpt_ena,
  input  logic [15:0]      pc_val,
  output logic             bkpt_hit
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_ADDR = 3'd1,
    F_MEM  = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [2:0]       tc_q, tc_d;
  logic [2:0]       fc_q, fc_d;
  logic             cond_q, cond_d;
  logic             bus_err_q, bus_err_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic             first_q, first_d;
  logic             exec_go;
`ifdef SEQ_BREAKPOINT_EN
  logic             bkpt_q, bkpt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      tc_q      <= '0;
      fc_q      <= '0;
      cond_q    <= 1'b0;
      bus_err_q <= 1'b0;
      ret_q     <= '0;
      first_q   <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      bkpt_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tc_q      <= tc_d;
      fc_q      <= fc_d;
      cond_q    <= cond_d;
      bus_err_q <= bus_err_d;
      ret_q     <= ret_d;
      first_q   <= first_d;
`ifdef SEQ_BREAKPOINT_EN
      bkpt_q    <= bkpt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tc_d       = tc_q;
    fc_d       = fc_q;
    cond_d     = cond_q;
    bus_err_d  = bus_err_q;
    ret_d      = ret_q;
    first_d    = 1'b0;
    exec_go    = 1'b0;
    mar_load   = 1'b0;
    mem_req    = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    exec_start = 1'b0;
    skipped    = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bkpt_d     = bkpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (run) state_d = F_ADDR;
      end
      F_ADDR: begin
`ifdef SEQ_BREAKPOINT_EN
        if (bkpt_ena && (pc_val == bkpt_addr)) begin
          bkpt_d  = 1'b1;
          state_d = HALT;
        end else begin
          mar_load = 1'b1;
          state_d  = F_MEM;
        end
`else
        mar_load = 1'b1;
        state_d  = F_MEM;
`endif
      end
      F_MEM: begin
        mem_req = 1'b1;
        // An ack in the expiry cycle still completes the fetch.
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          tmo_d   = '0;
          state_d = DECODE;
        end else if (tmo_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          tmo_d     = '0;
          state_d   = HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DECODE: begin
        // True-count slots are consumed before false-count slots.
        if (tc_q != 3'd0) begin
          exec_go = cond_q;
          tc_d    = tc_q - 3'd1;
        end else if (fc_q != 3'd0) begin
          exec_go = !cond_q;
          fc_d    = fc_q - 3'd1;
        end else begin
          exec_go = 1'b1;
        end
        if (exec_go) begin
          first_d = 1'b1;
          state_d = EXEC;
        end else begin
          skipped = 1'b1;
          state_d = run ? F_ADDR : IDLE;
        end
      end
      EXEC: begin
        exec_start = first_q;
        if (exec_done) begin
          ret_d = ret_q + 1'b1;
          if (cex_load) begin
            cond_d = cex_cond;
            tc_d   = cex_tc;
            fc_d   = cex_fc;
          end
          if (halt_instr) state_d = HALT;
          else            state_d = run ? F_ADDR : IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_rw     = 1'b0;
  assign cex_active = (tc_q != 3'd0) || (fc_q != 3'd0);
  assign halted     = (state_q == HALT);
  assign bus_err    = bus_err_q;
  assign ret_count  = ret_q;
  assign state_o    = state_q;
`ifdef SEQ_BREAKPOINT_EN
  assign bkpt_hit   = bkpt_q;
`endif

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Scoreboarded bench for instr_cycle_sequencer: directed instruction streams with hand-computed strobe traces.
module tb_instr_cycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        mar_load, mem_req, mem_rw, mem_ack;
  logic        ir_load, pc_inc, exec_start, exec_done;
  logic        halt_instr, cex_load, cex_cond;
  logic [2:0]  cex_tc, cex_fc;
  logic        skipped, cex_active, halted, bus_err;
  logic [15:0] ret_count;
  logic [2:0]  state_o;

  instr_cycle_sequencer #(.MEM_TIMEOUT(4), .RET_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mar_load(mar_load), .mem_req(mem_req), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc), .exec_start(exec_start), .exec_done(exec_done),
    .halt_instr(halt_instr), .cex_load(cex_load), .cex_cond(cex_cond),
    .cex_tc(cex_tc), .cex_fc(cex_fc), .skipped(skipped), .cex_active(cex_active),
    .halted(halted), .bus_err(bus_err), .ret_count(ret_count), .state_o(state_o)
  );

  typedef struct packed {
    logic       halt;
    logic       cl;
    logic       cond;
    logic [2:0] tc;
    logic [2:0] fc;
    logic [3:0] wt;
  } cfg_t;

  logic [15:0] exp_q[$];
  cfg_t        cfg_q[$];
  int          mem_wait;
  int          total;
  int          bad;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word: state, mar, req, ir, pc, exec_start, skipped, cex_active, halted, bus_err, ret_count[3:0]
  function automatic logic [15:0] mk(input int st, input int ml, input int rq, input int il,
                                     input int es, input int sk, input int ca, input int ha,
                                     input int be, input int rc);
    return {st[2:0], ml[0], rq[0], il[0], il[0], es[0], sk[0], ca[0], ha[0], be[0], rc[3:0]};
  endfunction

  function automatic logic [15:0] obs();
    return {state_o, mar_load, mem_req, ir_load, pc_inc, exec_start, skipped,
            cex_active, halted, bus_err, ret_count[3:0]};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // ---------------- responders ----------------
  initial begin
    int req_cnt;
    req_cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst_n && mem_req) begin
        if (mem_wait >= 0 && req_cnt == mem_wait) begin
          mem_ack = 1'b1;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  initial begin
    int   exec_cnt;
    cfg_t c;
    exec_cnt   = 0;
    exec_done  = 1'b0;
    halt_instr = 1'b0;
    cex_load   = 1'b0;
    cex_cond   = 1'b0;
    cex_tc     = 3'd0;
    cex_fc     = 3'd0;
    forever begin
      @(negedge clk);
      exec_done  = 1'b0;
      halt_instr = 1'b0;
      cex_load   = 1'b0;
      cex_cond   = 1'b0;
      cex_tc     = 3'd0;
      cex_fc     = 3'd0;
      if (rst_n && state_o == 3'd4 && cfg_q.size() > 0) begin
        if (exec_cnt == int'(cfg_q[0].wt)) begin
          c          = cfg_q.pop_front();
          exec_done  = 1'b1;
          halt_instr = c.halt;
          cex_load   = c.cl;
          cex_cond   = c.cond;
          cex_tc     = c.tc;
          cex_fc     = c.fc;
          exec_cnt   = 0;
        end else begin
          exec_cnt++;
        end
      end else begin
        exec_cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && (mar_load || mem_req || exec_start || skipped)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got %h expected none", obs());
        end else begin
          e = exp_q.pop_front();
          check("trace", obs(), e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fetch(input int mw, input int ca, input int rc);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, ca, 0, 0, rc));
    for (int i = 0; i < mw; i++) exp_q.push_back(mk(2, 0, 1, 0, 0, 0, ca, 0, 0, rc));
    exp_q.push_back(mk(2, 0, 1, 1, 0, 0, ca, 0, 0, rc));
  endtask

  task automatic push_exec(input int ca, input int rc);
    exp_q.push_back(mk(4, 0, 0, 0, 1, 0, ca, 0, 0, rc));
  endtask

  task automatic push_skip(input int ca, input int rc);
    exp_q.push_back(mk(3, 0, 0, 0, 0, 1, ca, 0, 0, rc));
  endtask

  task automatic run_pulse();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_mar(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 300 && seen < n; i++) begin
      @(negedge clk);
      if (mar_load) seen++;
    end
    if (seen < n) bound_fail(nm);
  endtask

  task automatic settle(input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < 300 && ok == 0; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && (state_o == 3'd0 || state_o == 3'd5)) ok = 1;
    end
    if (ok == 0) bound_fail(nm);
    @(negedge clk);
  endtask

  task automatic toggle_run();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run = (i % 2 == 0);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    total    = 0;
    bad      = 0;
    mem_wait = 1;
    run      = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", obs(), 16'h0000);
    check("mem_rw", {15'd0, mem_rw}, 16'h0000);
    rst_n = 1'b1;

    // Basic fetch: ack in 2nd req cycle, exec_done one cycle after exec_start, run dropped mid-instruction.
    mem_wait = 1;
    cfg_q.push_back('{halt: 1'b0, cl: 1'b0, cond: 1'b0, tc: 3'd0, fc: 3'd0, wt: 4'd1});
    push_fetch(1, 0, 0);
    push_exec(0, 0);
    run_pulse();
    settle("basic_settle");
    check("basic_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // CEX cond=0 tc=2 fc=1: two skips, then one executes.
    mem_wait = 0;
    cfg_q.push_back('{halt: 1'b0, cl: 1'b1, cond: 1'b0, tc: 3'd2, fc: 3'd1, wt: 4'd0});
    cfg_q.push_back('{halt: 1'b0, cl: 1'b0, cond: 1'b0, tc: 3'd0, fc: 3'd0, wt: 4'd2});
    push_fetch(0, 0, 1); push_exec(0, 1);
    push_fetch(0, 1, 2); push_skip(1, 2);
    push_fetch(0, 1, 2); push_skip(1, 2);
    push_fetch(0, 1, 2); push_exec(0, 2);
    @(negedge clk);
    run = 1'b1;
    wait_mar("cex1_mar", 4);
    run = 1'b0;
    settle("cex1_settle");
    check("cex1_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3));

    // CEX cond=1 tc=1 fc=3, then overwritten by cond=1 tc=0 fc=1.
    cfg_q.push_back('{halt: 1'b0, cl: 1'b1, cond: 1'b1, tc: 3'd1, fc: 3'd3, wt: 4'd0});
    cfg_q.push_back('{halt: 1'b0, cl: 1'b1, cond: 1'b1, tc: 3'd0, fc: 3'd1, wt: 4'd1});
    cfg_q.push_back('{halt: 1'b0, cl: 1'b0, cond: 1'b0, tc: 3'd0, fc: 3'd0, wt: 4'd0});
    push_fetch(0, 0, 3); push_exec(0, 3);
    push_fetch(0, 1, 4); push_exec(1, 4);
    push_fetch(0, 1, 5); push_skip(1, 5);
    push_fetch(0, 0, 5); push_exec(0, 5);
    @(negedge clk);
    run = 1'b1;
    wait_mar("cex2_mar", 4);
    run = 1'b0;
    settle("cex2_settle");
    check("cex2_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6));

    // Memory timeout: no ack, four request cycles, then HALT with bus_err.
    mem_wait = -1;
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 6));
    run_pulse();
    settle("tmo_settle");
    check("tmo_halt", obs(), mk(5, 0, 0, 0, 0, 0, 0, 1, 1, 6));
    toggle_run();
    check("tmo_hold", obs(), mk(5, 0, 0, 0, 0, 0, 0, 1, 1, 6));

    // Reset out of HALT, then asynchronous reset in the middle of a memory handshake.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("halt_reset", obs(), 16'h0000);
    rst_n = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    run_pulse();
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      if (mem_req) seen++;
      if (seen < 2) @(negedge clk);
    end
    if (seen < 2) bound_fail("async_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    check("async_queue", 16'(exp_q.size()), 16'h0000);

    // Ack arriving in the expiry cycle completes the fetch without error.
    mem_wait = 3;
    cfg_q.push_back('{halt: 1'b0, cl: 1'b0, cond: 1'b0, tc: 3'd0, fc: 3'd0, wt: 4'd0});
    push_fetch(3, 0, 0);
    push_exec(0, 0);
    run_pulse();
    settle("edge_ack_settle");
    check("edge_ack_idle", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Halt instruction: HALT is absorbing, run toggling issues nothing.
    mem_wait = 0;
    cfg_q.push_back('{halt: 1'b1, cl: 1'b0, cond: 1'b0, tc: 3'd0, fc: 3'd0, wt: 4'd1});
    push_fetch(0, 0, 1);
    push_exec(0, 1);
    run_pulse();
    settle("halt_settle");
    check("halt_instr", obs(), mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    toggle_run();
    check("halt_hold", obs(), mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    check("final_queue", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
